// File: rtl/sib_sync_event_mc.sv
// Multi-channel event synchronizer with per-channel pending counters.
// Toggle or rising-edge detection per channel, saturating counts, sticky overflow.
module sib_sync_event_mc #(
   parameter int             NCH         = 4,
   parameter int             SYNC_STAGES = 2,
   parameter bit             BYPASS      = 1'b0,
   parameter logic [NCH-1:0] RISE_MASK   = '0,
   parameter int             CNT_W       = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       evt_i,
   input  logic [NCH-1:0]       ack_i,
   input  logic [NCH-1:0]       ovf_clr_i,
   output logic                 ready_o,
   output logic [NCH-1:0]       evt_pulse_o,
   output logic [NCH-1:0]       pend_o,
   output logic [NCH*CNT_W-1:0] pend_cnt_o,
   output logic [NCH-1:0]       ovf_o
);

   localparam int               L    = BYPASS ? 1 : SYNC_STAGES + 1;
   localparam logic [CNT_W-1:0] CMAX = '1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           r_state;
   logic [2:0]       r_init_cnt;
   logic             r_ready;
   logic [NCH-1:0]   w_sync;
   logic [NCH-1:0]   r_prev;
   logic [NCH-1:0]   w_raw;
   logic [NCH-1:0]   w_evt;
   logic [NCH-1:0]   r_pulse;
   logic [NCH-1:0]   r_ovf;
   logic [NCH-1:0]   w_ovf_set;
   logic [CNT_W-1:0] r_cnt     [NCH];
   logic [CNT_W-1:0] w_cnt_nxt [NCH];

   generate
      if (BYPASS) begin : g_byp
         assign w_sync = evt_i;
      end else begin : g_sync
         logic [NCH-1:0] r_chain [SYNC_STAGES];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < SYNC_STAGES; i++) r_chain[i] <= '0;
            end else begin
               r_chain[0] <= evt_i;
               for (int i = 1; i < SYNC_STAGES; i++) r_chain[i] <= r_chain[i-1];
            end
         end

         assign w_sync = r_chain[SYNC_STAGES-1];
      end
   endgenerate

   assign w_raw = (RISE_MASK & w_sync & ~r_prev) | (~RISE_MASK & (w_sync ^ r_prev));
   assign w_evt = (r_state == S_RUN) ? w_raw : '0;

   // INIT spans the chain fill plus one prev update so stale levels never fire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_INIT;
         r_init_cnt <= '0;
         r_ready    <= 1'b0;
      end else begin
         unique case (r_state)
            S_INIT: begin
               if (r_init_cnt == 3'(L - 1)) begin
                  r_state <= S_RUN;
                  r_ready <= 1'b1;
               end else begin
                  r_init_cnt <= r_init_cnt + 3'd1;
               end
            end
            S_RUN: r_ready <= 1'b1;
            default: r_state <= S_INIT;
         endcase
      end
   end

   // A same-cycle ack only cancels an event when something is pending.
   always_comb begin
      for (int n = 0; n < NCH; n++) begin
         w_cnt_nxt[n] = r_cnt[n];
         w_ovf_set[n] = 1'b0;
         if (w_evt[n]) begin
            if (ack_i[n] && r_cnt[n] != '0) begin
               w_cnt_nxt[n] = r_cnt[n];
            end else if (ack_i[n]) begin
               w_cnt_nxt[n] = CNT_W'(1);
            end else if (r_cnt[n] == CMAX) begin
               w_ovf_set[n] = 1'b1;
            end else begin
               w_cnt_nxt[n] = r_cnt[n] + CNT_W'(1);
            end
         end else if (ack_i[n] && r_cnt[n] != '0) begin
            w_cnt_nxt[n] = r_cnt[n] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev  <= '0;
         r_pulse <= '0;
         r_ovf   <= '0;
         for (int n = 0; n < NCH; n++) r_cnt[n] <= '0;
      end else begin
         r_prev  <= w_sync;
         r_pulse <= w_evt;
         r_ovf   <= (r_ovf & ~ovf_clr_i) | w_ovf_set;
         for (int n = 0; n < NCH; n++) r_cnt[n] <= w_cnt_nxt[n];
      end
   end

   always_comb begin
      pend_o     = '0;
      pend_cnt_o = '0;
      for (int n = 0; n < NCH; n++) begin
         pend_o[n]                  = |r_cnt[n];
         pend_cnt_o[n*CNT_W +: CNT_W] = r_cnt[n];
      end
   end

   assign ready_o     = r_ready;
   assign evt_pulse_o = r_pulse;
   assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_sib_sync_event_mc.sv
// Bench for sib_sync_event_mc: synchronized config (rise on ch2, 2-bit counts)
// and a bypass config, with a pulse scoreboard keyed on expected cycle.
module tb_sib_sync_event_mc;

   typedef struct {
      int ch;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        qa[$];
   exp_t        qb[$];

   logic        rst_a, rst_b;
   logic [3:0]  evt_a, ack_a, clr_a;
   logic [3:0]  evt_b, ack_b, clr_b;
   logic        ready_a, ready_b;
   logic [3:0]  pulse_a, pend_a, ovf_a;
   logic [3:0]  pulse_b, pend_b, ovf_b;
   logic [7:0]  cnt_a;
   logic [15:0] cnt_b;

   sib_sync_event_mc #(
      .NCH(4), .SYNC_STAGES(2), .BYPASS(1'b0),
      .RISE_MASK(4'b0100), .CNT_W(2)
   ) u_a (
      .clk(clk), .rst_n(rst_a), .evt_i(evt_a), .ack_i(ack_a),
      .ovf_clr_i(clr_a), .ready_o(ready_a), .evt_pulse_o(pulse_a),
      .pend_o(pend_a), .pend_cnt_o(cnt_a), .ovf_o(ovf_a)
   );

   sib_sync_event_mc #(
      .NCH(4), .SYNC_STAGES(2), .BYPASS(1'b1),
      .RISE_MASK(4'b0000), .CNT_W(4)
   ) u_b (
      .clk(clk), .rst_n(rst_b), .evt_i(evt_b), .ack_i(ack_b),
      .ovf_clr_i(clr_b), .ready_o(ready_b), .evt_pulse_o(pulse_b),
      .pend_o(pend_b), .pend_cnt_o(cnt_b), .ovf_o(ovf_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int ca(input int ch);
      return int'(cnt_a[ch*2 +: 2]);
   endfunction

   function automatic int cb(input int ch);
      return int'(cnt_b[ch*4 +: 4]);
   endfunction

   task automatic tog_a(input int ch, input bit expect_pulse);
      exp_t e;
      evt_a[ch] = ~evt_a[ch];
      if (expect_pulse) begin
         e.ch  = ch;
         e.cyc = cyc + 3;
         qa.push_back(e);
      end
   endtask

   task automatic tog_b(input int ch);
      exp_t e;
      evt_b[ch] = ~evt_b[ch];
      e.ch  = ch;
      e.cyc = cyc + 1;
      qb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (qa.size() > 0 && qa[0].cyc < cyc) begin
         e = qa.pop_front();
         chk("pulseA_missing_cyc", cyc, e.cyc);
      end
      while (qb.size() > 0 && qb[0].cyc < cyc) begin
         e = qb.pop_front();
         chk("pulseB_missing_cyc", cyc, e.cyc);
      end
      for (int ch = 0; ch < 4; ch++) begin
         if (pulse_a[ch]) begin
            if (qa.size() == 0) begin
               chk("pulseA_unexpected", int'(pulse_a[ch]), 0);
            end else begin
               e = qa.pop_front();
               chk("pulseA_ch", ch, e.ch);
               chk("pulseA_cyc", cyc, e.cyc);
            end
         end
         if (pulse_b[ch]) begin
            if (qb.size() == 0) begin
               chk("pulseB_unexpected", int'(pulse_b[ch]), 0);
            end else begin
               e = qb.pop_front();
               chk("pulseB_ch", ch, e.ch);
               chk("pulseB_cyc", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      evt_a = 4'b0001; ack_a = '0; clr_a = '0;
      evt_b = '0;      ack_b = '0; clr_b = '0;
      step(2);
      chk("rstA_ready", int'(ready_a), 0);
      chk("rstA_cnt", int'(cnt_a), 0);
      chk("rstA_ovf", int'(ovf_a), 0);
      chk("rstB_ready", int'(ready_b), 0);

      // Static level on ch0 from release must be absorbed during INIT
      rst_a = 1'b1; rst_b = 1'b1;
      step(1);
      chk("bootA_ready_e1", int'(ready_a), 0);
      chk("bootB_ready_e1", int'(ready_b), 1);
      step(1);
      chk("bootA_ready_e2", int'(ready_a), 0);
      step(1);
      chk("bootA_ready_e3", int'(ready_a), 1);
      step(4);
      chk("bootA_cnt", int'(cnt_a), 0);
      chk("bootA_pend", int'(pend_a), 0);

      // Single toggle on ch1 then ack
      tog_a(1, 1'b1);
      step(3);
      chk("togA_cnt1", ca(1), 1);
      chk("togA_pend1", int'(pend_a[1]), 1);
      ack_a[1] = 1'b1;
      step(1);
      ack_a[1] = 1'b0;
      chk("ackA_cnt1", ca(1), 0);
      chk("ackA_pend1", int'(pend_a[1]), 0);

      // Rise-mode ch2 fires once per high pulse; toggle ch0 fires twice
      tog_a(2, 1'b1);
      step(4);
      tog_a(2, 1'b0);
      step(4);
      chk("riseA_cnt2", ca(2), 1);
      tog_a(0, 1'b1);
      step(4);
      tog_a(0, 1'b1);
      step(4);
      chk("togA_cnt0", ca(0), 2);
      ack_a = 4'b0101;
      step(1);
      ack_a = 4'b0001;
      step(1);
      ack_a = '0;
      chk("drainA_cnt0", ca(0), 0);
      chk("drainA_cnt2", ca(2), 0);

      // Event and ack together at count 0, then bare acks
      tog_a(3, 1'b1);
      step(2);
      ack_a[3] = 1'b1;
      step(1);
      ack_a[3] = 1'b0;
      chk("evtack0_cnt3", ca(3), 1);
      ack_a[3] = 1'b1;
      step(1);
      chk("ack1_cnt3", ca(3), 0);
      step(1);
      ack_a[3] = 1'b0;
      chk("ack0_cnt3", ca(3), 0);

      // Saturation of the 2-bit counter on ch0
      for (int i = 0; i < 3; i++) begin
         tog_a(0, 1'b1);
         step(4);
      end
      chk("sat3_cnt0", ca(0), 3);
      chk("sat3_ovf0", int'(ovf_a[0]), 0);
      tog_a(0, 1'b1);
      step(4);
      chk("sat4_cnt0", ca(0), 3);
      chk("sat4_ovf0", int'(ovf_a[0]), 1);
      tog_a(0, 1'b1);
      step(2);
      ack_a[0] = 1'b1;
      step(1);
      ack_a[0] = 1'b0;
      chk("satack_cnt0", ca(0), 3);
      chk("satack_ovf0", int'(ovf_a[0]), 1);
      step(1);
      clr_a[0] = 1'b1;
      step(1);
      clr_a[0] = 1'b0;
      chk("clr_ovf0", int'(ovf_a[0]), 0);
      chk("clr_cnt0", ca(0), 3);
      tog_a(0, 1'b1);
      step(2);
      clr_a[0] = 1'b1;
      step(1);
      clr_a[0] = 1'b0;
      chk("clrovf_ovf0", int'(ovf_a[0]), 1);
      chk("clrovf_cnt0", ca(0), 3);
      step(2);

      // Mid-operation reset with an in-flight toggle and a static high level
      tog_a(1, 1'b0);
      step(1);
      evt_a[2] = 1'b1;
      rst_a = 1'b0;
      #1;
      chk("midrstA_ready", int'(ready_a), 0);
      chk("midrstA_cnt", int'(cnt_a), 0);
      chk("midrstA_pend", int'(pend_a), 0);
      chk("midrstA_ovf", int'(ovf_a), 0);
      chk("midrstA_pulse", int'(pulse_a), 0);
      step(2);
      rst_a = 1'b1;
      step(6);
      chk("postrstA_ready", int'(ready_a), 1);
      chk("postrstA_cnt", int'(cnt_a), 0);
      chk("postrstA_ovf", int'(ovf_a), 0);

      // Bypass config: one-cycle latency, reset recovery in one cycle
      tog_b(3);
      step(1);
      chk("bypB_cnt3_1", cb(3), 1);
      tog_b(3);
      step(1);
      chk("bypB_cnt3_2", cb(3), 2);
      chk("bypB_pend3", int'(pend_b[3]), 1);
      step(1);
      evt_b[0] = 1'b1;
      rst_b = 1'b0;
      #1;
      chk("rstB_ready_low", int'(ready_b), 0);
      chk("rstB_cnt", int'(cnt_b), 0);
      chk("rstB_pend", int'(pend_b), 0);
      chk("rstB_pulse", int'(pulse_b), 0);
      chk("rstB_ovf", int'(ovf_b), 0);
      step(1);
      rst_b = 1'b1;
      step(1);
      chk("rstB_ready_back", int'(ready_b), 1);
      step(3);
      chk("rstB_cnt_after", int'(cnt_b), 0);

      step(4);
      chk("qa_empty", qa.size(), 0);
      chk("qb_empty", qb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
